// File: rtl/param_chain_loader.sv
// Serial neuron-parameter chain: bytes shift in at the top slot, frame completes after DEPTH accepts.
// Define PARAM_READBACK_EN to make cmd 11 rotate the chain and expose slot 0 on rd_data.
module param_chain_loader #(
   parameter  int DATA_W    = 8,
   parameter  int N_NEURONS = 4,
   parameter  int N_INPUTS  = 4,
   localparam int PER_N     = N_INPUTS + 2,
   localparam int DEPTH     = N_NEURONS * PER_N,
   localparam int CNT_W     = $clog2(DEPTH + 1)
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [1:0]              cmd,
   input  logic                    in_valid,
   input  logic [DATA_W-1:0]       in_data,
   output logic                    in_ready,
   output logic [DEPTH*DATA_W-1:0] params_flat,
   output logic [CNT_W-1:0]        load_count,
   output logic                    params_valid,
   output logic                    frame_done,
   output logic [DATA_W-1:0]       rd_data
);
   localparam int              W          = DEPTH * DATA_W;
   localparam logic [1:0]      CMD_LOAD   = 2'b01;
   localparam logic [1:0]      CMD_CLEAR  = 2'b10;
   localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(DEPTH - 1);

   logic accept;

   // Once a frame is complete the chain is frozen until an explicit clear.
   assign in_ready = (cmd == CMD_LOAD) && !params_valid;
   assign accept   = in_valid && in_ready;

`ifdef PARAM_READBACK_EN
   localparam logic [1:0] CMD_ROT = 2'b11;
`endif

   // Slot 0 lives in the low bits, so a shift moves everything down one slot.
   always_ff @(posedge clk) begin
      frame_done <= 1'b0;
      if (reset) begin
         params_flat  <= '0;
         load_count   <= '0;
         params_valid <= 1'b0;
      end else if (accept) begin
         params_flat <= {in_data, params_flat[W-1:DATA_W]};
         load_count  <= load_count + CNT_W'(1);
         if (load_count == LAST_SLOT) begin
            params_valid <= 1'b1;
            frame_done   <= 1'b1;
         end
      end else if (cmd == CMD_CLEAR) begin
         params_flat  <= '0;
         load_count   <= '0;
         params_valid <= 1'b0;
`ifdef PARAM_READBACK_EN
      end else if (cmd == CMD_ROT) begin
         params_flat <= {params_flat[DATA_W-1:0], params_flat[W-1:DATA_W]};
`endif
      end
   end

`ifdef PARAM_READBACK_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_data <= '0;
      end else if (cmd == CMD_ROT) begin
         rd_data <= params_flat[DATA_W-1:0];
      end
   end
`else
   assign rd_data = '0;
`endif

endmodule

// File: tb/tb_param_chain_loader.sv
// Scoreboard bench for param_chain_loader: queue-based reference model, per-cycle expected state.
module tb_param_chain_loader;
   localparam int DATA_W = 8;
   localparam int DEPTH  = 24;
   localparam int W      = DEPTH * DATA_W;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic [1:0]        cmd = 2'b00;
   logic              in_valid = 1'b0;
   logic [DATA_W-1:0] in_data = '0;
   logic              in_ready;
   logic [W-1:0]      params_flat;
   logic [4:0]        load_count;
   logic              params_valid;
   logic              frame_done;
   logic [DATA_W-1:0] rd_data;

   param_chain_loader dut (
      .clk(clk), .reset(reset), .cmd(cmd), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready), .params_flat(params_flat), .load_count(load_count),
      .params_valid(params_valid), .frame_done(frame_done), .rd_data(rd_data)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0]      p;
      int                cnt;
      logic              pv;
      logic              fd;
      logic [DATA_W-1:0] rd;
   } exp_t;

   exp_t expq[$];
   int   checks = 0;
   int   errors = 0;

   // Reference model: the chain is a queue of bytes, slot 0 at the front.
   logic [DATA_W-1:0] slots[$];
   int                m_cnt = 0;
   logic              m_pv = 1'b0;
   logic              m_fd = 1'b0;
   logic [DATA_W-1:0] m_rd = '0;

   task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("FAIL %s got %0h expected %0h at %0t", nm, act, want, $time);
      end
   endtask

   function automatic logic [W-1:0] pack_slots();
      logic [W-1:0] f = '0;
      for (int k = 0; k < DEPTH; k++) f[k*DATA_W +: DATA_W] = slots[k];
      return f;
   endfunction

   task automatic zero_slots();
      slots.delete();
      for (int k = 0; k < DEPTH; k++) slots.push_back('0);
   endtask

   task automatic step(input logic r, input logic [1:0] c, input logic v, input logic [DATA_W-1:0] d);
      exp_t e;
      @(negedge clk);
      reset = r; cmd = c; in_valid = v; in_data = d;
      #1;
      chk("in_ready", W'(in_ready), W'(c == 2'b01 && !m_pv));
      m_fd = 1'b0;
      if (r) begin
         zero_slots(); m_cnt = 0; m_pv = 1'b0; m_rd = '0;
      end else begin
         case (c)
            2'b01: if (v && !m_pv) begin
               void'(slots.pop_front());
               slots.push_back(d);
               m_cnt++;
               if (m_cnt == DEPTH) begin m_pv = 1'b1; m_fd = 1'b1; end
            end
            2'b10: begin zero_slots(); m_cnt = 0; m_pv = 1'b0; end
`ifdef PARAM_READBACK_EN
            2'b11: begin m_rd = slots[0]; slots.push_back(slots.pop_front()); end
`endif
            default: ;
         endcase
      end
      e.p = pack_slots(); e.cnt = m_cnt; e.pv = m_pv; e.fd = m_fd; e.rd = m_rd;
      expq.push_back(e);
   endtask

   // Moves to just after the edge that consumed the last step.
   task automatic peek();
      @(posedge clk);
      #2;
   endtask

   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (expq.size() > 0) begin
            e = expq.pop_front();
            chk("params_flat", params_flat, e.p);
            chk("load_count", W'(load_count), W'(e.cnt));
            chk("params_valid", W'(params_valid), W'(e.pv));
            chk("frame_done", W'(frame_done), W'(e.fd));
            chk("rd_data", W'(rd_data), W'(e.rd));
         end
      end
   end

   task automatic load_seq(input int n, input int base);
      for (int k = 0; k < n; k++) step(1'b0, 2'b01, 1'b1, DATA_W'(base + k));
   endtask

   initial begin
      int got;
      logic [W-1:0] snap;
      zero_slots();
      step(1'b1, 2'b00, 1'b0, '0);
      step(1'b1, 2'b01, 1'b1, 8'h55);
      peek();
      chk("reset_flat", params_flat, '0);
      chk("reset_count", W'(load_count), '0);

      // Frame of 1..24 back-to-back.
      load_seq(DEPTH, 1);
      peek();
      chk("t1_frame_done", W'(frame_done), W'(1));
      chk("t1_slot0", W'(params_flat[0 +: 8]), W'(1));
      chk("t1_slot5", W'(params_flat[5*8 +: 8]), W'(6));
      chk("t1_slot23", W'(params_flat[23*8 +: 8]), W'(24));
      chk("t1_in_ready", W'(in_ready), W'(0));
      snap = params_flat;

      // Byte after completion must be refused.
      step(1'b0, 2'b01, 1'b1, 8'hAA);
      peek();
      chk("t2_flat", params_flat, snap);
      chk("t2_count", W'(load_count), W'(24));
      chk("t2_frame_done", W'(frame_done), W'(0));

      // Clear, then split frame with a hold and toggling valid.
      step(1'b0, 2'b10, 1'b1, 8'h77);
      peek();
      chk("t4_flat", params_flat, '0);
      chk("t4_valid", W'(params_valid), W'(0));
      step(1'b0, 2'b01, 1'b0, '0);
      peek();
      chk("t4_in_ready", W'(in_ready), W'(1));
      load_seq(10, 100);
      for (int k = 0; k < 5; k++) step(1'b0, 2'b00, 1'b1, 8'hEE);
      peek();
      chk("t3_hold_count", W'(load_count), W'(10));
      got = 0;
      for (int k = 0; k < 100 && got < 14; k++) begin
         step(1'b0, 2'b01, k[0], DATA_W'(110 + got));
         if (k[0]) got++;
      end
      chk("t3_accepts", W'(got), W'(14));
      peek();
      chk("t3_slot0", W'(params_flat[0 +: 8]), W'(100));
      chk("t3_slot23", W'(params_flat[23*8 +: 8]), W'(123));

      // Reset mid-frame, then a fresh full frame.
      step(1'b0, 2'b10, 1'b0, '0);
      load_seq(7, 50);
      step(1'b1, 2'b01, 1'b1, 8'h99);
      peek();
      chk("t5_count", W'(load_count), '0);
      chk("t5_flat", params_flat, '0);
      load_seq(DEPTH, 200);
      peek();
      chk("t5_valid", W'(params_valid), W'(1));

`ifdef PARAM_READBACK_EN
      step(1'b0, 2'b10, 1'b0, '0);
      load_seq(DEPTH, 1);
      snap = pack_slots();
      for (int k = 0; k < DEPTH; k++) begin
         step(1'b0, 2'b11, 1'b0, '0);
         peek();
         chk("t6_rd_data", W'(rd_data), W'(k + 1));
      end
      chk("t6_restored", params_flat, snap);
`endif

      // Randomised traffic against the model.
      for (int n = 0; n < 3000; n++) begin
         int r;
         logic [1:0] c;
         r = $urandom_range(0, 99);
         if (r < 70)      c = 2'b01;
         else if (r < 85) c = 2'b00;
         else if (r < 88) c = 2'b10;
         else             c = 2'b11;
         step(($urandom_range(0, 299) == 0), c, ($urandom_range(0, 3) != 0),
              DATA_W'($urandom_range(0, 255)));
      end

      peek();
      peek();
      chk("queue_drained", W'(expq.size()), '0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end
endmodule
